// File: rtl/wirelog_pkg.sv
// Shared types and default sizing for the wire-logic gate driver family.
package wirelog_pkg;

  localparam int N_SRC_DEF = 4;
  localparam int CNT_W_DEF = 4;

  // Frame-level emission state of the gate driver.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SPENT = 2'd2
  } gate_state_e;

endpackage

// File: rtl/gate_driver_if.sv
// Trigger/frame inputs and wire/status outputs of the gate driver.
interface gate_driver_if
  import wirelog_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             logic_reset;
  logic [N_SRC-1:0] trig;
  logic             wire_out;
  logic             fire;
  logic [CNT_W-1:0] pending;
  logic             overflow;

  modport master (
    output logic_reset, trig,
    input  wire_out, fire, pending, overflow
  );

  modport slave (
    input  logic_reset, trig,
    output wire_out, fire, pending, overflow
  );

endinterface

// File: rtl/gate_popcount.sv
// Combinational count of set bits in a vector.
module gate_popcount #(
  parameter int N = 4
) (
  input  logic [N-1:0]             vec,
  output logic [$clog2(N+1)-1:0]   count
);

  localparam int CW = $clog2(N + 1);

  // Sum the individual bits of vec.
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/gate_driver.sv
// Gate driver: accumulates trigger requests and emits at most one wire
// toggle per logic frame, with a saturating pending counter.
module gate_driver
  import wirelog_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  gate_driver_if.slave bus
);

  localparam int PC_W  = $clog2(N_SRC + 1);
  localparam int SUM_W = CNT_W + PC_W;
  localparam logic [SUM_W-1:0] PEND_MAX = {{PC_W{1'b0}}, {CNT_W{1'b1}}};

  gate_state_e      state, state_nx;
  logic [CNT_W-1:0] pending, pend_nx;
  logic [PC_W-1:0]  trig_cnt;
  logic [SUM_W-1:0] sum;
  logic             emit;
  logic             drop;
  logic             wire_q;
  logic             fire_q;
  logic             overflow_q;

  gate_popcount #(.N(N_SRC)) u_popcount (
    .vec   (bus.trig),
    .count (trig_cnt)
  );

  // Next-state, next-pending and emission decision for this cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    state_nx = state;
    emit     = (state == ARMED) && !bus.logic_reset;
    sum      = SUM_W'(pending) + SUM_W'(trig_cnt) - SUM_W'(emit);
    drop     = 1'b0;
    pend_nx  = sum[CNT_W-1:0];

    if (sum > PEND_MAX) begin
      pend_nx = {CNT_W{1'b1}};
      drop    = 1'b1;
    end

    unique case (state)
      IDLE:    if (pend_nx != '0) state_nx = ARMED;
      ARMED:   if (emit) state_nx = SPENT;
      SPENT:   if (bus.logic_reset) state_nx = (pend_nx != '0) ? ARMED : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, counter and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples values from
    // before the edge, independent of statement order.
    if (reset) begin
      state      <= IDLE;
      pending    <= '0;
      wire_q     <= 1'b0;
      fire_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state   <= state_nx;
      pending <= pend_nx;
      fire_q  <= emit;
      if (emit) wire_q <= ~wire_q;
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign bus.wire_out = wire_q;
  assign bus.fire     = fire_q;
  assign bus.pending  = pending;
  assign bus.overflow = overflow_q;

endmodule

// File: doc/gate_driver.md
GATE_DRIVER -- requirements
Module: Gate_Driver

Interface
REQ-001 SHALL have parameter N_SRC, default 4: number of trigger sources.
REQ-002 SHALL have parameter CNT_W, default 4: pending-counter width.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge clk.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high full reset.
REQ-005 SHALL have port logic_reset, input, 1: one-cycle logic-frame boundary strobe.
REQ-006 SHALL have port trig, input, N_SRC: one-cycle trigger pulses; each set bit is one toggle request.
REQ-007 SHALL have port wire_out, output, 1: registered wire level; every emission is one level toggle.
REQ-008 SHALL have port fire, output, 1: registered one-cycle pulse, coincident with each wire_out toggle.
REQ-009 SHALL have port pending, output, CNT_W: registered count of unserved requests.
REQ-010 SHALL have port overflow, output, 1: sticky flag; a request was lost to saturation.

Function
REQ-011 SHALL implement a state register with states IDLE (pending==0, not spent), ARMED (pending>0, not spent) and SPENT (one toggle already emitted this frame).
REQ-012 SHALL, each cycle, add popcount(trig) to pending at the next edge.
REQ-013 SHALL emit when the state is ARMED and logic_reset is low: at that edge wire_out inverts, fire=1, pending decrements by 1, and the state goes to SPENT.
REQ-014 SHALL emit at most one toggle per frame; in SPENT, requests accumulate and no emission occurs.
REQ-015 SHALL, on logic_reset in SPENT, go to ARMED if the next pending is >0 and to IDLE otherwise.
REQ-016 SHALL, on logic_reset in ARMED, suppress emission that cycle, stay ARMED, and allow emission on the following cycle.
REQ-017 SHALL, for a trigger in cycle t from IDLE with no logic_reset, register pending=1 and ARMED at edge t; toggle wire_out and pulse fire at edge t+1.
REQ-018 SHALL, when emission and triggers coincide, compute next pending = pending + popcount(trig) - 1.
REQ-019 SHALL compute the sum at CNT_W+$clog2(N_SRC+1) bits and saturate pending at 2^CNT_W-1; excess requests are dropped.
REQ-020 SHALL set overflow on any drop; overflow clears only on reset.
REQ-021 SHALL drive fire low in every cycle without an emission.
REQ-022 SHALL leave wire_out unchanged by logic_reset and by reaching pending==0.
REQ-023 SHALL ignore trig bits beyond N_SRC (none exist; width-exact).

Reset
REQ-024 SHALL, on reset, set wire_out=0, fire=0, pending=0, overflow=0 and state=IDLE at the next edge.
REQ-025 SHALL give reset priority over logic_reset and trig in the same cycle; requests in the reset cycle are discarded.
REQ-026 SHALL, on reset mid-frame in SPENT or ARMED, drop all pending requests and perform no toggle.

Structure
REQ-027 SHALL take the state enum (IDLE/ARMED/SPENT) and default N_SRC/CNT_W constants from shared package Wirelog_Pkg.
REQ-028 SHALL instantiate one sub-module, Gate_Popcount (parameter N; combinational count of set bits, output $clog2(N+1) bits).
REQ-029 SHALL use no latches, no multi-clock logic and no initial-block dependence for functional state.

Verification
REQ-030 SHALL cover: reset, then trig=0001 at cycle 0 -> pending=1 after edge 0; wire_out 0->1 and fire=1 after edge 1; pending=0; state SPENT.
REQ-031 SHALL cover: trig=1111 once, then logic_reset every 10 cycles -> exactly one toggle per frame; after 4 frames wire_out=0 and pending=0.
REQ-032 SHALL cover: in ARMED with pending=3, trig=0011 in the emission cycle -> pending=4 after the edge, fire=1.
REQ-033 SHALL cover: CNT_W=4, pending=14, trig=1111 in SPENT -> pending=15 and overflow=1; overflow stays 1 through logic_reset and clears only on reset.
REQ-034 SHALL cover: logic_reset asserted in the cycle an ARMED emission would occur -> no toggle that cycle; toggle on the next cycle.
REQ-035 SHALL cover: reset asserted with pending=5 in SPENT and trig=0001 -> all outputs 0 next cycle; no toggle on the following logic_reset.
